// File: rtl/trail_pkg.sv
// trail_pkg: shared FSM state type and width helper for the assignment trail stack.
package trail_pkg;
    typedef enum logic [1:0] {IDLE, UNWIND, DONE} trail_state_e;

    function automatic int level_w_f(input int max_levels);
        return $clog2(max_levels + 1);
    endfunction
endpackage

// File: rtl/trail_mem.sv
// trail_mem: register-file entry storage, one write port, one asynchronous read port.
module trail_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/trail_stack.sv
// trail_stack: LIFO assignment trail with decision levels and a multi-cycle
// backtrack that streams popped entries out on a ready/valid undo port.
module trail_stack
    import trail_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 16,
    parameter int MAX_LEVELS = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              push,
    input  logic [WIDTH-1:0]                  push_data,
    input  logic                              push_decision,
    output logic                              push_ready,
    input  logic                              bt_valid,
    input  logic [$clog2(MAX_LEVELS+1)-1:0]   bt_level,
    output logic                              bt_ready,
    output logic                              bt_done,
    output logic                              undo_valid,
    output logic [WIDTH-1:0]                  undo_data,
    input  logic                              undo_ready,
    input  logic                              clear,
    output logic [WIDTH-1:0]                  top_data,
    output logic [$clog2(DEPTH):0]            count,
    output logic [$clog2(MAX_LEVELS+1)-1:0]   level,
    output logic                              full,
    output logic                              empty,
    output logic                              overflow
);
    localparam int LW = level_w_f(MAX_LEVELS);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);

    trail_state_e  state, state_nx;
    logic [LW-1:0] tgt, tgt_up, level_nx;
    logic [CW-1:0] level_start [1:MAX_LEVELS];
    logic [CW-1:0] start;
    logic [WIDTH-1:0] rd;
    logic at_max, do_push, dec_push, ovf_ev, accept, pop;

    assign at_max     = level == LW'(MAX_LEVELS);
    assign full       = count == CW'(DEPTH);
    assign empty      = count == '0;
    assign bt_ready   = state == IDLE;
    assign push_ready = bt_ready && !full;
    assign bt_done    = state == DONE && !clear;
    assign accept     = bt_valid && bt_ready;
    assign do_push    = push && push_ready && !clear && !(push_decision && at_max);
    assign dec_push   = do_push && push_decision;
    assign ovf_ev     = push && bt_ready && (full || (push_decision && at_max));
    // A same-cycle push is applied before the backtrack, so compare against the updated level.
    assign level_nx   = level + LW'(dec_push);
    assign tgt_up     = tgt + 1'b1;
    assign start      = level_start[tgt_up];
    assign undo_valid = state == UNWIND && count > start && !clear;
    assign pop        = undo_valid && undo_ready;
    assign undo_data  = rd;
    assign top_data   = rd;

    trail_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (do_push),
        .waddr (AW'(count)),
        .wdata (push_data),
        .raddr (AW'(count - 1'b1)),
        .rdata (rd)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = !bt_valid ? IDLE : (bt_level >= level_nx) ? DONE : UNWIND;
            UNWIND:  state_nx = (!undo_valid || (pop && count == start + 1'b1)) ? DONE : UNWIND;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= clear ? IDLE : state_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            level    <= '0;
            tgt      <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            count    <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            count <= do_push ? count + 1'b1 : pop ? count - 1'b1 : count;
            // A target at or above the current level leaves the level untouched.
            level <= (state == DONE && tgt < level) ? tgt : level_nx;
            if (accept) tgt <= bt_level;
            if (ovf_ev) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk)
        if (dec_push) level_start[level_nx] <= count;
endmodule

// File: tb/tb_trail_stack.sv
// tb_trail_stack: directed and randomized checks of trail_stack against a queue-based model.
module tb_trail_stack;
    logic        clk = 1'b0;
    logic        rst_n, push, push_decision, bt_valid, undo_ready, clear;
    logic [31:0] push_data;
    logic [3:0]  bt_level;
    logic        push_ready, bt_ready, bt_done, undo_valid, full, empty, overflow;
    logic [31:0] undo_data, top_data;
    logic [4:0]  count;
    logic [3:0]  level;

    int tests = 0;
    int fails = 0;
    int lat;

    logic [31:0] q[$];
    int          starts[$];
    bit          ovf;

    trail_stack #(.WIDTH(32), .DEPTH(16), .MAX_LEVELS(8)) dut (
        .clk(clk), .rst_n(rst_n), .push(push), .push_data(push_data),
        .push_decision(push_decision), .push_ready(push_ready), .bt_valid(bt_valid),
        .bt_level(bt_level), .bt_ready(bt_ready), .bt_done(bt_done),
        .undo_valid(undo_valid), .undo_data(undo_data), .undo_ready(undo_ready),
        .clear(clear), .top_data(top_data), .count(count), .level(level),
        .full(full), .empty(empty), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        starts.delete();
        ovf = 1'b0;
    endtask

    task automatic model_push(input logic [31:0] d, input bit dec);
        if (q.size() == 16 || (dec && starts.size() == 8)) ovf = 1'b1;
        else begin
            if (dec) starts.push_back(q.size());
            q.push_back(d);
        end
    endtask

    task automatic check_state();
        check("count", count, q.size());
        check("level", level, starts.size());
        check("overflow", overflow, ovf);
        check("empty", empty, q.size() == 0);
        check("full", full, q.size() == 16);
        check("push_ready", push_ready, q.size() != 16);
        check("bt_ready", bt_ready, 1);
        check("undo_idle", undo_valid, 0);
        check("bt_done_idle", bt_done, 0);
        if (q.size() > 0) check("top_data", top_data, q[$]);
    endtask

    task automatic do_push(input logic [31:0] d, input bit dec);
        push = 1'b1; push_data = d; push_decision = dec;
        model_push(d, dec);
        @(posedge clk); #1;
        push = 1'b0; push_decision = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        model_reset();
    endtask

    // mode 0: always ready, 1: ready on even cycles, 2: random ready
    task automatic backtrack(input int lvl, input int mode, input bit wp,
                             input logic [31:0] wd, input bit wdec, output int lat_o);
        int beats = 0, stalls = 0, c = 1, nexp, keep;
        bit done = 0;
        if (wp) model_push(wd, wdec);
        keep = (lvl < starts.size()) ? starts[lvl] : q.size();
        nexp = q.size() - keep;
        bt_valid = 1'b1; bt_level = 4'(lvl);
        push = wp; push_data = wd; push_decision = wdec;
        @(posedge clk); #1;
        bt_valid = 1'b0; push = 1'b0; push_decision = 1'b0;
        lat_o = -1;
        while (!done && c <= 200) begin
            undo_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
            #1;
            check("bt_ready_busy", bt_ready, 0);
            if (bt_done) begin
                done = 1;
                lat_o = c;
                check("bt_latency", c, beats + stalls + 1);
                check("bt_beats", beats, nexp);
                check("undo_at_done", undo_valid, 0);
            end else if (undo_valid) begin
                if (beats >= nexp) check("extra_undo", undo_valid, 0);
                else begin
                    check("undo_data", undo_data, q[$]);
                    if (undo_ready) begin q.delete(q.size() - 1); beats++; end
                    else stalls++;
                end
            end
            @(posedge clk); #1;
            c++;
        end
        undo_ready = 1'b0;
        if (!done) check("bt_timeout", done, 1);
        while (q.size() > keep) q.delete(q.size() - 1);
        while (starts.size() > lvl) starts.delete(starts.size() - 1);
        check("bt_done_after", bt_done, 0);
        check_state();
    endtask

    task automatic build_base();
        do_push(32'h10, 0); do_push(32'h11, 0); do_push(32'h20, 1);
        do_push(32'h21, 0); do_push(32'h30, 1);
    endtask

    initial begin
        rst_n = 1'b0; push = 0; push_decision = 0; bt_valid = 0; undo_ready = 0;
        clear = 0; push_data = '0; bt_level = '0;
        model_reset();
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        check_state();

        build_base();
        check_state();
        check("base_count", count, 5);
        check("base_level", level, 2);
        check("base_top", top_data, 32'h30);

        backtrack(0, 0, 0, '0, 0, lat);
        check("bt0_latency", lat, 4);
        check("bt0_count", count, 2);

        do_push(32'h20, 1); do_push(32'h21, 0); do_push(32'h30, 1);
        backtrack(0, 1, 0, '0, 0, lat);
        check("bt0_stall_latency", lat, 7);

        do_push(32'h20, 1); do_push(32'h21, 0); do_push(32'h30, 1);
        backtrack(3, 0, 0, '0, 0, lat);
        check("noop_latency", lat, 1);
        check("noop_level", level, 2);

        backtrack(2, 0, 1, 32'h40, 1, lat);
        check("samecycle_latency", lat, 2);

        do_clear();
        for (int i = 0; i < 17; i++) do_push(32'(i + 'h100), 0);
        check_state();
        check("fill_ovf", overflow, 1);

        do_clear();
        check_state();
        for (int i = 0; i < 9; i++) do_push(32'(i + 'h200), 1);
        check_state();
        check("lvl_ovf_level", level, 8);

        do_clear();
        build_base();
        bt_valid = 1'b1; bt_level = 4'd0;
        @(posedge clk); #1;
        bt_valid = 1'b0; undo_ready = 1'b1;
        #1 check("clr_first_beat", undo_data, 32'h30);
        @(posedge clk); #1;
        clear = 1'b1;
        #1 check("clr_undo_gated", undo_valid, 0);
        @(posedge clk); #1;
        clear = 1'b0; undo_ready = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            check_state();
            @(posedge clk); #1;
        end

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) < 6)
                do_push($urandom, $urandom_range(0, 3) == 0);
            else
                backtrack($urandom_range(0, starts.size() + 1), 2, $urandom_range(0, 3) == 0,
                          $urandom, $urandom_range(0, 1), lat);
            check_state();
        end

        push = 1'b1; push_data = 32'hdead; push_decision = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_count", count, 0);
        check("rst_level", level, 0);
        check("rst_empty", empty, 1);
        check("rst_overflow", overflow, 0);
        check("rst_bt_ready", bt_ready, 1);
        push = 1'b0; push_decision = 1'b0;
        model_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check_state();
        do_push(32'h55, 1);
        check_state();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
